// File: rtl/if_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response and the IF/ID
// valid/ready handshake. Optional id_exc_adel follows FETCH_ALIGN_CHECK_EN.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        id_exc_adel;
`endif

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
`ifdef FETCH_ALIGN_CHECK_EN
    output id_exc_adel,
`endif
    input  imem_rvalid, imem_rdata, id_ready
  );

  // Memory / decode side
  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
`ifdef FETCH_ALIGN_CHECK_EN
    input  id_exc_adel,
`endif
    output imem_rvalid, imem_rdata, id_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, IF/ID holding register,
// flush/drain handling, sticky timeout error.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned PCs complete as a NOP with
// id_exc_adel set instead of issuing a memory request.
module if_fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc_in,
  output logic                  pc_hold,
  input  logic                  flush,
  output logic                  fetch_err,
  if_fetch_unit_if.master       bus
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN, S_ERR} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc_plus4;
  logic        r_fetch_err;
  logic        r_exc_adel;

  logic        w_issue;
  logic        w_capture;
  logic        w_drop_valid;
  logic        w_cnt_clr;
  logic        w_timeout;
  logic        w_misalign;
  logic        w_tmo_hit;

  assign w_tmo_hit = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and control strobes for the datapath
  always_comb begin
    w_next       = r_state;
    pc_hold      = 1'b1;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    w_drop_valid = 1'b0;
    w_cnt_clr    = 1'b0;
    w_timeout    = 1'b0;
    w_misalign   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush) begin
          pc_hold = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
          if (pc_in[1:0] != 2'b00) begin
            w_misalign = 1'b1;
            w_next     = S_HOLD;
          end else begin
            w_issue   = 1'b1;
            w_cnt_clr = 1'b1;
            w_next    = S_WAIT;
          end
`else
          w_issue   = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = S_WAIT;
`endif
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          if (!flush) begin
            w_capture = 1'b1;
            w_next    = S_HOLD;
          end else begin
            w_next = S_IDLE;
          end
        end else if (flush) begin
          w_cnt_clr = 1'b1;
          w_next    = S_DRAIN;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_next    = S_ERR;
        end
      end
      S_DRAIN: begin
        if (bus.imem_rvalid) begin
          w_next = S_IDLE;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_next    = S_ERR;
        end
      end
      S_HOLD: begin
        // Flush and consume both just retire the entry; flush needs no extra priority.
        if (flush || bus.id_ready) begin
          w_drop_valid = 1'b1;
          w_next       = S_IDLE;
        end
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // Request, IF/ID register, timeout counter and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= '0;
      r_id_valid    <= 1'b0;
      r_id_instr    <= '0;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= 32'd4;
      r_fetch_err   <= 1'b0;
      r_exc_adel    <= 1'b0;
    end else begin
      r_imem_req <= w_issue;
      if (w_issue) r_imem_addr <= pc_in;
      if (w_cnt_clr) r_cnt <= '0;
      else if (r_state == S_WAIT || r_state == S_DRAIN) r_cnt <= r_cnt + 8'd1;
      if (w_capture) begin
        r_id_instr    <= bus.imem_rdata;
        r_id_pc       <= r_imem_addr;
        r_id_pc_plus4 <= r_imem_addr + 32'd4;
        r_id_valid    <= 1'b1;
      end
      if (w_misalign) begin
        r_id_instr    <= '0;
        r_id_pc       <= pc_in;
        r_id_pc_plus4 <= pc_in + 32'd4;
        r_id_valid    <= 1'b1;
        r_exc_adel    <= 1'b1;
      end
      if (w_drop_valid) begin
        r_id_valid <= 1'b0;
        r_exc_adel <= 1'b0;
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
        r_id_valid  <= 1'b0;
      end
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_imem_addr;
  assign bus.id_valid    = r_id_valid;
  assign bus.id_instr    = r_id_instr;
  assign bus.id_pc       = r_id_pc;
  assign bus.id_pc_plus4 = r_id_pc_plus4;
  assign fetch_err       = r_fetch_err;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.id_exc_adel = r_exc_adel;
`else
  logic w_unused_exc;
  assign w_unused_exc = r_exc_adel;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: fetch/handshake, stall, flush/drain,
// flush-with-response, PC+4 wrap, timeout, and the optional alignment check.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_hold;
  logic        flush;
  logic        fetch_err;
  int unsigned total = 0;
  int unsigned bad = 0;

  if_fetch_unit_if bus();

  if_fetch_unit #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_hold(pc_hold),
    .flush(flush), .fetch_err(fetch_err), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; pc_in = 32'h0; flush = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b1;
    tick(); tick();
    chk("rst_req",   {31'b0, bus.imem_req}, 32'h0);
    chk("rst_addr",  bus.imem_addr, 32'h0);
    chk("rst_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("rst_instr", bus.id_instr, 32'h0);
    chk("rst_pc",    bus.id_pc, 32'h0);
    chk("rst_pc4",   bus.id_pc_plus4, 32'h4);
    chk("rst_err",   {31'b0, fetch_err}, 32'h0);

    // Fetch at 0, one-cycle memory, decode ready
    reset = 1'b0; #1;
    chk("idle_hold", {31'b0, pc_hold}, 32'h0);
    tick();
    chk("t1_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("t1_addr", bus.imem_addr, 32'h0);
    chk("t1_hold", {31'b0, pc_hold}, 32'h1);
    pc_in = 32'h4; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2408000A;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("t1_valid", {31'b0, bus.id_valid}, 32'h1);
    chk("t1_instr", bus.id_instr, 32'h2408000A);
    chk("t1_pc",    bus.id_pc, 32'h0);
    chk("t1_pc4",   bus.id_pc_plus4, 32'h4);
    chk("t1_req0",  {31'b0, bus.imem_req}, 32'h0);
    tick();
    chk("t1_cons",  {31'b0, bus.id_valid}, 32'h0);
    chk("t1_ihold", {31'b0, pc_hold}, 32'h0);
    tick();
    chk("t2_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("t2_addr", bus.imem_addr, 32'h4);
    pc_in = 32'h8; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h8C090004;
    bus.id_ready = 1'b0;
    tick();
    bus.imem_rvalid = 1'b0;
    // Decode stalls for 5 cycles; one stray rvalid must be ignored
    for (int i = 0; i < 5; i++) begin
      bus.imem_rvalid = (i == 2); bus.imem_rdata = 32'hFFFF0000;
      #1;
      chk("t2_phold", {31'b0, pc_hold}, 32'h1);
      tick();
      chk("t2_valid", {31'b0, bus.id_valid}, 32'h1);
      chk("t2_instr", bus.id_instr, 32'h8C090004);
      chk("t2_pc",    bus.id_pc, 32'h4);
      chk("t2_pc4",   bus.id_pc_plus4, 32'h8);
      chk("t2_noreq", {31'b0, bus.imem_req}, 32'h0);
    end
    bus.imem_rvalid = 1'b0; bus.id_ready = 1'b1;
    tick();
    chk("t2_cons",  {31'b0, bus.id_valid}, 32'h0);
    chk("t2_req0",  {31'b0, bus.imem_req}, 32'h0);
    tick();
    chk("t2_req1",  {31'b0, bus.imem_req}, 32'h1);
    chk("t2_addr8", bus.imem_addr, 32'h8);
    pc_in = 32'hC;

    // Flush one cycle into WAIT, memory latency 3
    flush = 1'b1; pc_in = 32'h100; #1;
    chk("t3_fhold", {31'b0, pc_hold}, 32'h1);
    tick();
    flush = 1'b0;
    chk("t3_req0",  {31'b0, bus.imem_req}, 32'h0);
    tick();
    chk("t3_drain", {31'b0, pc_hold}, 32'h1);
    chk("t3_dvld",  {31'b0, bus.id_valid}, 32'h0);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("t3_novld", {31'b0, bus.id_valid}, 32'h0);
    chk("t3_idle",  {31'b0, pc_hold}, 32'h0);
    tick();
    chk("t3_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("t3_addr", bus.imem_addr, 32'h100);
    pc_in = 32'h104;

    // Flush together with rvalid
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h11111111; flush = 1'b1; pc_in = 32'h200;
    tick();
    bus.imem_rvalid = 1'b0; flush = 1'b0; #1;
    chk("t4_vld0", {31'b0, bus.id_valid}, 32'h0);
    chk("t4_idle", {31'b0, pc_hold}, 32'h0);
    tick();
    chk("t4_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("t4_addr", bus.imem_addr, 32'h200);
    pc_in = 32'h204; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h22222222;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("t4_vld1",  {31'b0, bus.id_valid}, 32'h1);
    chk("t4_instr", bus.id_instr, 32'h22222222);
    // Flush in HOLD with decode ready
    flush = 1'b1; pc_in = 32'h300;
    tick();
    flush = 1'b0;
    chk("t4_fvld", {31'b0, bus.id_valid}, 32'h0);
    chk("t4_freq", {31'b0, bus.imem_req}, 32'h0);
    tick();
    chk("t4_req2",  {31'b0, bus.imem_req}, 32'h1);
    chk("t4_addr2", bus.imem_addr, 32'h300);
    pc_in = 32'h304;

    // Memory never responds: error 255 edges after entering WAIT
    for (int i = 0; i < 254; i++) tick();
    chk("t5_noerr", {31'b0, fetch_err}, 32'h0);
    tick();
    chk("t5_err",  {31'b0, fetch_err}, 32'h1);
    chk("t5_vld",  {31'b0, bus.id_valid}, 32'h0);
    bus.imem_rvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_noreq", {31'b0, bus.imem_req}, 32'h0);
    end
    bus.imem_rvalid = 1'b0;
    chk("t5_phold", {31'b0, pc_hold}, 32'h1);
    chk("t5_stick", {31'b0, fetch_err}, 32'h1);
    reset = 1'b1;
    tick();
    chk("t5_rclr", {31'b0, fetch_err}, 32'h0);
    chk("t5_rpc4", bus.id_pc_plus4, 32'h4);
    reset = 1'b0;

    // PC+4 wraps at the top of the address space
    pc_in = 32'hFFFFFFFC;
    tick();
    chk("wr_addr", bus.imem_addr, 32'hFFFFFFFC);
    pc_in = 32'h0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00000013;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("wr_pc",  bus.id_pc, 32'hFFFFFFFC);
    chk("wr_pc4", bus.id_pc_plus4, 32'h0);
    tick();
    chk("wr_cons", {31'b0, bus.id_valid}, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned PC completes as NOP with exception flag, no request
    pc_in = 32'h6;
    tick();
    chk("al_req",   {31'b0, bus.imem_req}, 32'h0);
    chk("al_valid", {31'b0, bus.id_valid}, 32'h1);
    chk("al_instr", bus.id_instr, 32'h0);
    chk("al_exc",   {31'b0, bus.id_exc_adel}, 32'h1);
    chk("al_pc",    bus.id_pc, 32'h6);
    pc_in = 32'h8;
    tick();
    chk("al_cvld", {31'b0, bus.id_valid}, 32'h0);
    chk("al_cexc", {31'b0, bus.id_exc_adel}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
